// File: rtl/alsu_pipe.sv
// rtl/alsu_pipe.sv - two-stage parametrised ALSU with valid/ready handshake
module alsu_pipe #(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_W          = 16,
    parameter int    ERR_W          = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   A,
    input  logic signed [WIDTH-1:0]   B,
    input  logic [2:0]                opcode,
    input  logic                      cin,
    input  logic                      serial_in,
    input  logic                      direction,
    input  logic                      red_op_A,
    input  logic                      red_op_B,
    input  logic                      bypass_A,
    input  logic                      bypass_B,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH-1:0] out,
    output logic                      invalid,
    output logic [LED_W-1:0]          leds,
    output logic [ERR_W-1:0]          err_cnt
);
    localparam int OW      = 2 * WIDTH;
    localparam bit PRIO_B  = (INPUT_PRIORITY == "B");
    localparam bit USE_CIN = (FULL_ADDER == "ON");

    typedef enum logic [2:0] {
        OP_OR     = 3'd0,
        OP_XOR    = 3'd1,
        OP_ADD    = 3'd2,
        OP_MULT   = 3'd3,
        OP_SHIFT  = 3'd4,
        OP_ROTATE = 3'd5
    } opcode_e;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
        logic             cin;
        logic             serial;
        logic             dir;
        logic             red_a;
        logic             red_b;
        logic             byp_a;
        logic             byp_b;
    } req_t;

    req_t             s1_req_q, s1_req_d;
    logic             s1_valid_q, s1_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [OW-1:0]    out_q, out_d;
    logic             invalid_q, invalid_d;
    logic [LED_W-1:0] leds_q, leds_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             adv2, accept, load2;
    logic [OW-1:0]    a_ext, b_ext, cin_ext;
    logic [WIDTH-1:0] red_src;
    logic [OW-1:0]    res_out;
    logic             res_inv;
    logic             use_a;

    // Result computation from the registered stage-1 request.
    always_comb begin
        a_ext   = {{WIDTH{s1_req_q.a[WIDTH-1]}}, s1_req_q.a};
        b_ext   = {{WIDTH{s1_req_q.b[WIDTH-1]}}, s1_req_q.b};
        cin_ext = {{(OW-1){1'b0}}, (USE_CIN ? s1_req_q.cin : 1'b0)};
        use_a   = s1_req_q.byp_a && !(s1_req_q.byp_b && PRIO_B);
        if (s1_req_q.red_a && s1_req_q.red_b) begin
            red_src = PRIO_B ? s1_req_q.b : s1_req_q.a;
        end else if (s1_req_q.red_a) begin
            red_src = s1_req_q.a;
        end else begin
            red_src = s1_req_q.b;
        end
        res_out = '0;
        res_inv = 1'b0;
        if (s1_req_q.byp_a || s1_req_q.byp_b) begin
            res_out = use_a ? a_ext : b_ext;
        end else if (s1_req_q.op >= 3'd6 ||
                     ((s1_req_q.red_a || s1_req_q.red_b) &&
                      s1_req_q.op != OP_OR && s1_req_q.op != OP_XOR)) begin
            res_inv = 1'b1;
        end else begin
            case (s1_req_q.op)
                OP_OR: begin
                    if (s1_req_q.red_a || s1_req_q.red_b) begin
                        res_out = {{(OW-1){1'b0}}, |red_src};
                    end else begin
                        res_out = a_ext | b_ext;
                    end
                end
                OP_XOR: begin
                    if (s1_req_q.red_a || s1_req_q.red_b) begin
                        res_out = {{(OW-1){1'b0}}, ^red_src};
                    end else begin
                        res_out = a_ext ^ b_ext;
                    end
                end
                OP_ADD:  res_out = a_ext + b_ext + cin_ext;
                OP_MULT: res_out = a_ext * b_ext;
                OP_SHIFT: begin
                    if (s1_req_q.dir) begin
                        res_out = {out_q[OW-2:0], s1_req_q.serial};
                    end else begin
                        res_out = {s1_req_q.serial, out_q[OW-1:1]};
                    end
                end
                OP_ROTATE: begin
                    if (s1_req_q.dir) begin
                        res_out = {out_q[OW-2:0], out_q[OW-1]};
                    end else begin
                        res_out = {out_q[0], out_q[OW-1:1]};
                    end
                end
                default: res_out = '0;
            endcase
        end
    end

    // Stage 2 only loads when stage 1 holds a request, so out stays put for SHIFT/ROTATE.
    always_comb begin
        adv2     = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || adv2;
        accept   = in_valid && in_ready;
        load2    = adv2 && s1_valid_q;

        s1_req_d = s1_req_q;
        if (accept) begin
            s1_req_d.a      = A;
            s1_req_d.b      = B;
            s1_req_d.op     = opcode;
            s1_req_d.cin    = cin;
            s1_req_d.serial = serial_in;
            s1_req_d.dir    = direction;
            s1_req_d.red_a  = red_op_A;
            s1_req_d.red_b  = red_op_B;
            s1_req_d.byp_a  = bypass_A;
            s1_req_d.byp_b  = bypass_B;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        out_valid_d = adv2 ? s1_valid_q : out_valid_q;
        out_d       = load2 ? res_out : out_q;
        invalid_d   = load2 ? res_inv : invalid_q;
        err_cnt_d   = err_cnt_q;
        if (load2 && res_inv && err_cnt_q != {ERR_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
        leds_d = (out_valid_q && invalid_q) ? ~leds_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_req_q    <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            invalid_q   <= 1'b0;
            leds_q      <= '0;
            err_cnt_q   <= '0;
        end else begin
            s1_req_q    <= s1_req_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            invalid_q   <= invalid_d;
            leds_q      <= leds_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign invalid   = invalid_q;
    assign leds      = leds_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_alsu_pipe.sv
// tb/tb_alsu_pipe.sv - self-checking bench for alsu_pipe (WIDTH=3 defaults)
module tb_alsu_pipe;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready;
    logic signed [2:0] A, B;
    logic [2:0]        opcode;
    logic              cin, serial_in, direction;
    logic              red_op_A, red_op_B, bypass_A, bypass_B;
    logic              out_valid, out_ready;
    logic signed [5:0] out;
    logic              invalid;
    logic [15:0]       leds;
    logic [7:0]        err_cnt;

    always #5 clk = ~clk;

    alsu_pipe #(.WIDTH(3), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(16), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
        .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .invalid(invalid), .leds(leds), .err_cnt(err_cnt)
    );

    typedef struct {
        int op; int a; int b;
        bit cin; bit ser; bit dir; bit ra; bit rb; bit ba; bit bb;
        int exp_out; bit exp_inv;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        opcode = 3'(v.op); A = 3'(v.a); B = 3'(v.b);
        cin = v.cin; serial_in = v.ser; direction = v.dir;
        red_op_A = v.ra; red_op_B = v.rb; bypass_A = v.ba; bypass_B = v.bb;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One request with no backpressure: result must appear exactly one edge after accept.
    task automatic xact(input vec_t v, input string name);
        int n;
        drive(v); in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        check({name, "_accept"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_lat0"}, out_valid, 0);
        @(posedge clk); #1;
        check({name, "_valid"}, out_valid, 1);
        check({name, "_out"}, $unsigned(out), v.exp_out & 63);
        check({name, "_inv"}, invalid, v.exp_inv);
    endtask

    // Reference: decode rules in plain integer arithmetic on 6-bit results.
    function automatic int ref_out(input vec_t v, input int prev, output bit inv);
        int ua, ub, s, r;
        inv = 1'b0;
        ua = v.a & 7; ub = v.b & 7;
        if (v.ba || v.bb) return (v.ba ? v.a : v.b) & 63;
        if (v.op >= 6 || ((v.ra || v.rb) && v.op > 1)) begin inv = 1'b1; return 0; end
        case (v.op)
            0, 1: begin
                if (v.ra || v.rb) begin
                    s = v.ra ? ua : ub;
                    if (v.op == 0) return (s != 0) ? 1 : 0;
                    return $countones(s) & 1;
                end
                r = (v.op == 0) ? (ua | ub) : (ua ^ ub);
                if (r >= 4) r = r - 8;
                return r & 63;
            end
            2: return (v.a + v.b + int'(v.cin)) & 63;
            3: return (v.a * v.b) & 63;
            4: return v.dir ? (((prev << 1) | int'(v.ser)) & 63) : ((prev >> 1) | (int'(v.ser) << 5));
            default: return v.dir ? (((prev << 1) | (prev >> 5)) & 63) : ((prev >> 1) | ((prev & 1) << 5));
        endcase
    endfunction

    vec_t       tbl[16];
    vec_t       v;
    logic [6:0] exp_q[$];
    logic [6:0] e;
    int         model_out, model_err, o;
    bit         inv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          op  a   b  cin ser dir ra rb ba bb  out    inv
        tbl[0]  = '{2,  3,  3, 1, 0, 0, 0, 0, 0, 0, 'h07, 0};
        tbl[1]  = '{3, -4, -4, 0, 0, 0, 0, 0, 0, 0, 'h10, 0};
        tbl[2]  = '{3,  3, -4, 0, 0, 0, 0, 0, 0, 0, 'h34, 0};
        tbl[3]  = '{0, -3,  2, 0, 0, 0, 0, 0, 0, 0, 'h3F, 0};
        tbl[4]  = '{1, -2,  3, 0, 0, 0, 0, 0, 0, 0, 'h3D, 0};
        tbl[5]  = '{1, -4,  0, 0, 0, 0, 1, 0, 0, 0, 'h01, 0};
        tbl[6]  = '{0, -1,  0, 0, 0, 0, 0, 1, 0, 0, 'h00, 0};
        tbl[7]  = '{1,  3,  1, 0, 0, 0, 1, 1, 0, 0, 'h00, 0};
        tbl[8]  = '{6, -2,  1, 0, 0, 0, 0, 0, 1, 1, 'h3E, 0};
        tbl[9]  = '{2,  0, -1, 0, 0, 0, 0, 0, 0, 1, 'h3F, 0};
        tbl[10] = '{7,  1,  1, 0, 0, 0, 0, 0, 0, 0, 'h00, 1};
        tbl[11] = '{3,  1,  1, 0, 0, 0, 0, 1, 0, 0, 'h00, 1};
        tbl[12] = '{2, -4, -4, 1, 0, 0, 0, 0, 0, 0, 'h39, 0};
        tbl[13] = '{2,  1,  2, 0, 0, 0, 0, 0, 0, 0, 'h03, 0};
        tbl[14] = '{7,  3,  0, 0, 0, 0, 1, 0, 1, 0, 'h03, 0};
        tbl[15] = '{0,  3,  0, 0, 0, 0, 1, 1, 0, 0, 'h01, 0};

        v = tbl[0]; drive(v);
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", $unsigned(out), 0);
        check("rst_invalid", invalid, 0);
        check("rst_leds", leds, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) xact(tbl[i], $sformatf("tbl%0d", i));

        // SHIFT/ROTATE operate on the previously loaded result
        v = '{2, 3, 3, 1, 0, 0, 0, 0, 0, 0, 'h07, 0}; xact(v, "sh_preload");
        v = '{4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h0E, 0}; xact(v, "sh_left");
        v = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h07, 0}; xact(v, "rot_right1");
        v = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h23, 0}; xact(v, "rot_right2");

        // invalid results, leds blink under stall, err_cnt
        do_reset();
        out_ready = 1'b0;
        v = '{6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}; drive(v); in_valid = 1'b1;
        @(posedge clk); #1;
        v = '{2, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1}; drive(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("inv_valid", out_valid, 1);
        check("inv_out", $unsigned(out), 0);
        check("inv_flag", invalid, 1);
        check("inv_leds0", leds, 16'h0000);
        check("inv_err1", err_cnt, 1);
        check("inv_in_ready", in_ready, 0);
        @(posedge clk); #1; check("inv_leds1", leds, 16'hFFFF);
        @(posedge clk); #1; check("inv_leds2", leds, 16'h0000);
        @(posedge clk); #1; check("inv_leds3", leds, 16'hFFFF);
        check("inv_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("inv2_valid", out_valid, 1);
        check("inv2_flag", invalid, 1);
        check("inv2_out", $unsigned(out), 0);
        check("inv2_err2", err_cnt, 2);
        v = '{0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 'h03, 0}; drive(v); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("or_gap_valid", out_valid, 0);
        @(posedge clk); #1;
        check("or_valid", out_valid, 1);
        check("or_out", $unsigned(out), 'h03);
        check("or_inv", invalid, 0);
        check("or_leds_clear", leds, 16'h0000);
        @(posedge clk); #1;
        check("or_leds_stay", leds, 16'h0000);
        check("or_err_keep", err_cnt, 2);

        // backpressure: 2 of 3 accepted, held SHIFT shifts once, in-order delivery
        do_reset();
        out_ready = 1'b0;
        v = '{2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; drive(v); in_valid = 1'b1;
        @(posedge clk); #1;
        v = '{4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0}; drive(v);
        @(posedge clk); #1;
        v = '{3, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0}; drive(v);
        check("bp_valid", out_valid, 1);
        check("bp_out_r1", $unsigned(out), 'h02);
        check("bp_in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_out%0d", k), $unsigned(out), 'h02);
            check($sformatf("bp_hold_valid%0d", k), out_valid, 1);
            check($sformatf("bp_hold_ready%0d", k), in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_release", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_out_r2_shift_once", $unsigned(out), 'h05);
        check("bp_valid_r2", out_valid, 1);
        @(posedge clk); #1;
        check("bp_out_r3", $unsigned(out), 'h06);
        check("bp_valid_r3", out_valid, 1);
        @(posedge clk); #1;
        check("bp_drained", out_valid, 0);
        @(posedge clk); #1;
        check("bp_no_dup", out_valid, 0);

        // asynchronous reset mid-stream
        do_reset();
        out_ready = 1'b0;
        v = '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}; drive(v); in_valid = 1'b1;
        @(posedge clk); #1;
        v = '{2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; drive(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mr_pre_valid", out_valid, 1);
        check("mr_pre_err", err_cnt, 1);
        check("mr_pre_ready", in_ready, 0);
        #3 rst_n = 1'b0;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_out", $unsigned(out), 0);
        check("mr_invalid", invalid, 0);
        check("mr_leds", leds, 0);
        check("mr_err", err_cnt, 0);
        check("mr_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mr_hold_valid", out_valid, 0);
        v = '{2, 3, 3, 1, 0, 0, 0, 0, 0, 0, 'h07, 0}; xact(v, "mr_after");
        check("mr_after_err", err_cnt, 0);

        // randomized traffic against the reference model
        do_reset();
        model_out = 0; model_err = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            v.op  = int'($urandom_range(0, 7));
            v.a   = int'($urandom_range(0, 7)) - 4;
            v.b   = int'($urandom_range(0, 7)) - 4;
            v.cin = 1'($urandom_range(0, 1));
            v.ser = 1'($urandom_range(0, 1));
            v.dir = 1'($urandom_range(0, 1));
            v.ra  = ($urandom_range(0, 5) == 0);
            v.rb  = ($urandom_range(0, 5) == 0);
            v.ba  = ($urandom_range(0, 7) == 0);
            v.bb  = ($urandom_range(0, 7) == 0);
            drive(v);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_out", $unsigned(out), e[5:0]);
                    check("rnd_inv", invalid, e[6]);
                end
            end
            if (in_valid && in_ready) begin
                o = ref_out(v, model_out, inv);
                model_out = o;
                if (inv) model_err++;
                exp_q.push_back({inv, o[5:0]});
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("rnd_drain_spurious", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_drain_out", $unsigned(out), e[5:0]);
                    check("rnd_drain_inv", invalid, e[6]);
                end
            end
            @(posedge clk); #1;
        end
        check("rnd_queue_empty", exp_q.size(), 0);
        check("rnd_err_cnt", err_cnt, (model_err > 255) ? 255 : model_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alsu_pipe.md
Name: alsu_pipe

Overview:
- Parametrised, pipelined successor of the 3-bit ALSU.
- Operand width, LED width and adder mode are generics.
- Adds a valid/ready handshake on input and output, a 2-stage pipeline with backpressure, an explicit invalid flag and a saturating error counter.
- Sits between the stimulus/driver interface and the result checker.
- Opcode encoding is the shared opcode_e: OR=0, XOR=1, ADD=2, MULT=3, SHIFT=4, ROTATE=5, 6/7 invalid.

Parameters:
- WIDTH, 3, signed operand width; out is 2*WIDTH.
- INPUT_PRIORITY, "A", operand chosen when both bypass or both reduction flags are set ("A" or "B").
- FULL_ADDER, "ON", "ON" adds cin in ADD; "OFF" ignores cin.
- LED_W, 16, width of leds.
- ERR_W, 8, width of the saturating err_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage 1 can accept.
- A, B  in  WIDTH  signed operands.
- opcode  in  3  operation.
- cin  in  1  carry-in.
- serial_in  in  1  shift fill bit.
- direction  in  1  1=left, 0=right.
- red_op_A, red_op_B  in  1  reduction select.
- bypass_A, bypass_B  in  1  bypass select.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out  out  2*WIDTH  signed result.
- invalid  out  1  current result is invalid.
- leds  out  LED_W  error blink.
- err_cnt  out  ERR_W  invalid results produced, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - s1_valid=0, out_valid=0, out=0, invalid=0, leds=0, err_cnt=0.
  - Takes effect immediately, mid-operation included; in-flight requests are discarded.
- Handshake and pipeline:
  - Accept when in_valid && in_ready. Stage 1 registers all inputs.
  - adv2 = !out_valid || out_ready.
  - in_ready = !s1_valid || adv2 (combinational).
  - On adv2, stage 2 loads the computed result and out_valid <= s1_valid.
  - Latency: accept at edge N gives out_valid at edge N+1 with no stall. Full throughput is 1 per cycle.
  - While out_valid && !out_ready: out, invalid and out_valid hold; stage 1 holds; in_ready=0 once s1_valid=1.
- Decode priority (stage-1 registered values), evaluated in this order:
  1. bypass_A && bypass_B: A or B per INPUT_PRIORITY. bypass_A alone: A. bypass_B alone: B. Sign-extended to 2*WIDTH; invalid=0.
  2. Invalid if opcode is 6 or 7, or if (red_op_A || red_op_B) and opcode is not OR/XOR: out=0, invalid=1.
  3. OR/XOR:
     - Both reduction flags: reduce the INPUT_PRIORITY operand.
     - red_op_A: |A or ^A. red_op_B: |B or ^B.
     - Reduction results are zero-extended.
     - Otherwise A|B or A^B, sign-extended.
  4. ADD: A+B(+cin when FULL_ADDER="ON"), signed, sign-extended; never overflows 2*WIDTH.
  5. MULT: signed A*B, exact in 2*WIDTH.
  6. SHIFT:
     - Operates on the current out register, whether valid, invalid or 0.
     - direction=1: {out[2W-2:0], serial_in}. direction=0: {serial_in, out[2W-1:1]}.
  7. ROTATE: direction=1: {out[2W-2:0], out[2W-1]}. direction=0: {out[0], out[2W-1:1]}.
- SHIFT/ROTATE source out is the value at the adv2 edge, so a stall never double-shifts.
- leds:
  - Toggle every clock (~leds) while out_valid && invalid, first toggle going to all-ones.
  - Cleared to 0 on the first edge where that condition is false.
- err_cnt: +1 on each adv2 edge that loads an invalid result with s1_valid=1; saturates at 2^ERR_W-1.
- A request entering stage 1 while stage 2 stalls is neither lost nor duplicated.

Test Plan:
- Reset, then ADD A=3 B=3 cin=1 (FULL_ADDER="ON") -> out_valid one edge after accept, out=7 (6'b000111), invalid=0.
- MULT A=-4 B=-4 -> out=16 (6'b010000); MULT A=3 B=-4 -> out=-12 (6'b110100).
- opcode=6, then opcode=ADD with red_op_A=1 -> out=0 and invalid=1 for both; leds alternate 16'hFFFF/16'h0000 while held; err_cnt=2; a following valid OR clears leds to 0.
- Preload out=6'b000111; SHIFT direction=1 serial_in=0 -> 6'b001110. Then ROTATE direction=0 -> 6'b000111. Then ROTATE direction=0 again -> 6'b100011.
- Backpressure: out_ready=0, send 3 back-to-back requests -> 2 accepted, in_ready=0, out held stable; raise out_ready -> results delivered in order, none lost or duplicated; a SHIFT held under stall shifts exactly once.
- Assert rst_n=0 mid-stream with s1_valid=1 and out_valid=1 -> all outputs 0 immediately (before next edge); after release, first accepted request yields the correct result; err_cnt=0.
